// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared raster timing constants and width helper
package vga_timing_pkg;

    // 1920x1080, 2200x1125 total, positive sync polarity
    localparam int H_ACTIVE_1080 = 1920;
    localparam int H_FP_1080     = 88;
    localparam int H_SYNC_1080   = 44;
    localparam int H_BP_1080     = 148;
    localparam int H_TOTAL_1080  = H_ACTIVE_1080 + H_FP_1080 + H_SYNC_1080 + H_BP_1080;

    localparam int V_ACTIVE_1080 = 1080;
    localparam int V_FP_1080     = 4;
    localparam int V_SYNC_1080   = 5;
    localparam int V_BP_1080     = 36;
    localparam int V_TOTAL_1080  = V_ACTIVE_1080 + V_FP_1080 + V_SYNC_1080 + V_BP_1080;

    localparam int X_W_1080 = $clog2(H_TOTAL_1080);
    localparam int Y_W_1080 = $clog2(V_TOTAL_1080);

    // 1280x720, 1650x750 total, positive sync polarity
    localparam int H_ACTIVE_720 = 1280;
    localparam int H_FP_720     = 110;
    localparam int H_SYNC_720   = 40;
    localparam int H_BP_720     = 220;
    localparam int H_TOTAL_720  = H_ACTIVE_720 + H_FP_720 + H_SYNC_720 + H_BP_720;

    localparam int V_ACTIVE_720 = 720;
    localparam int V_FP_720     = 5;
    localparam int V_SYNC_720   = 5;
    localparam int V_BP_720     = 20;
    localparam int V_TOTAL_720  = V_ACTIVE_720 + V_FP_720 + V_SYNC_720 + V_BP_720;

    localparam int X_W_720 = $clog2(H_TOTAL_720);
    localparam int Y_W_720 = $clog2(V_TOTAL_720);

    // Bits needed to hold 0..total-1, never less than one bit
    function automatic int cnt_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrapping counter with active/sync window decode
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = H_ACTIVE_1080,
    parameter int FP     = H_FP_1080,
    parameter int SYNC   = H_SYNC_1080,
    parameter int BP     = H_BP_1080,
    parameter int W      = cnt_width(ACTIVE + FP + SYNC + BP)
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_count,
    output logic         o_last,
    output logic         o_zero,
    output logic         o_active,
    output logic         o_sync
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    localparam logic [W-1:0] C_LAST       = W'(TOTAL - 1);
    localparam logic [W-1:0] C_ACTIVE     = W'(ACTIVE);
    localparam logic [W-1:0] C_SYNC_START = W'(ACTIVE + FP);
    localparam logic [W-1:0] C_SYNC_END   = W'(ACTIVE + FP + SYNC);

    logic [W-1:0] r_count;

    // Advance on i_inc, wrapping explicitly at the last position of the axis
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= o_last ? '0 : r_count + W'(1);
        end
    end

    assign o_count  = r_count;
    assign o_last   = (r_count == C_LAST);
    assign o_zero   = (r_count == '0);
    assign o_active = (r_count < C_ACTIVE);
    assign o_sync   = (r_count >= C_SYNC_START) && (r_count < C_SYNC_END);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing generator with registered position, syncs and strobes
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_1080,
    parameter int H_FP      = H_FP_1080,
    parameter int H_SYNC    = H_SYNC_1080,
    parameter int H_BP      = H_BP_1080,
    parameter int V_ACTIVE  = V_ACTIVE_1080,
    parameter int V_FP      = V_FP_1080,
    parameter int V_SYNC    = V_SYNC_1080,
    parameter int V_BP      = V_BP_1080,
    parameter bit H_POL     = 1'b1,
    parameter bit V_POL     = 1'b1,
    parameter int FRAME_DIV = 4,
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int X_W      = cnt_width(H_TOTAL),
    localparam int Y_W      = cnt_width(V_TOTAL)
)(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    output logic [X_W-1:0] sx,
    output logic [Y_W-1:0] sy,
    output logic           hsync,
    output logic           vsync,
    output logic           de,
    output logic           line_start,
    output logic           frame_start,
    output logic           frame_tick
);

    localparam int FC_W = cnt_width(FRAME_DIV);
    localparam logic [FC_W-1:0] C_FC_LAST = FC_W'(FRAME_DIV - 1);

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || FRAME_DIV < 1) begin : g_param_check
        $error("vga_timing_gen: porch, sync and active sizes and FRAME_DIV must all be >= 1");
    end

    logic [X_W-1:0] w_hc;
    logic [Y_W-1:0] w_vc;
    logic           w_h_last;
    logic           w_h_zero;
    logic           w_h_active;
    logic           w_h_sync;
    logic           w_v_last;
    logic           w_v_zero;
    logic           w_v_active;
    logic           w_v_sync;
    logic           w_v_inc;
    logic           w_frame_start;

    logic [FC_W-1:0] r_fc;

    // The vertical axis steps once per line, on the enabled edge where hc wraps
    assign w_v_inc       = en && w_h_last;
    assign w_frame_start = w_h_zero && w_v_zero;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .W      (X_W)
    ) u_h_axis (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_inc    (en),
        .o_count  (w_hc),
        .o_last   (w_h_last),
        .o_zero   (w_h_zero),
        .o_active (w_h_active),
        .o_sync   (w_h_sync)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .W      (Y_W)
    ) u_v_axis (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_inc    (w_v_inc),
        .o_count  (w_vc),
        .o_last   (w_v_last),
        .o_zero   (w_v_zero),
        .o_active (w_v_active),
        .o_sync   (w_v_sync)
    );

    // Register the decode of the current (hc,vc) so every output describes the same pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sx          <= '0;
            sy          <= '0;
            de          <= 1'b0;
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_tick  <= 1'b0;
            r_fc        <= '0;
        end else if (en) begin
            sx          <= w_hc;
            sy          <= w_vc;
            de          <= w_h_active && w_v_active;
            hsync       <= w_h_sync ? H_POL : ~H_POL;
            vsync       <= w_v_sync ? V_POL : ~V_POL;
            line_start  <= w_h_zero;
            frame_start <= w_frame_start;
            frame_tick  <= w_frame_start && (r_fc == '0);
            if (w_frame_start) begin
                r_fc <= (r_fc == C_FC_LAST) ? '0 : r_fc + FC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

    logic clk;
    logic rst_n;
    logic en;

    // Small raster: 15 x 8 total, 8 x 4 active, hsync hc 10..12, vsync vc 5..6, 120 cycles/frame
    logic [3:0] s_sx;
    logic [2:0] s_sy;
    logic       s_hs, s_vs, s_de, s_ls, s_fs, s_ft;

    // Default 1080p raster
    logic [11:0] h_sx;
    logic [10:0] h_sy;
    logic        h_hs, h_vs, h_de, h_ls, h_fs, h_ft;

    int n_cmp = 0;
    int n_bad = 0;

    vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .H_POL (1'b1), .V_POL (1'b1), .FRAME_DIV (4)
    ) u_small (
        .clk (clk), .rst_n (rst_n), .en (en),
        .sx (s_sx), .sy (s_sy), .hsync (s_hs), .vsync (s_vs), .de (s_de),
        .line_start (s_ls), .frame_start (s_fs), .frame_tick (s_ft)
    );

    vga_timing_gen u_hd (
        .clk (clk), .rst_n (rst_n), .en (en),
        .sx (h_sx), .sy (h_sy), .hsync (h_hs), .vsync (h_vs), .de (h_de),
        .line_start (h_ls), .frame_start (h_fs), .frame_tick (h_ft)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset, then release with en=1 and take the first enabled edge (pixel 0 presented)
    task automatic start();
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        en    = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (3) tick();
        n_cmp++; if ({s_sx, s_sy} !== 7'd0) begin n_bad++; $display("FAIL reset_pos: got sx=%0d sy=%0d, expected 0 0", s_sx, s_sy); end
        n_cmp++; if ({s_de, s_hs, s_vs} !== 3'b000) begin n_bad++; $display("FAIL reset_de_sync: got %b, expected 000", {s_de, s_hs, s_vs}); end
        n_cmp++; if ({s_ls, s_fs, s_ft} !== 3'b000) begin n_bad++; $display("FAIL reset_strobes: got %b, expected 000", {s_ls, s_fs, s_ft}); end
        n_cmp++; if ({h_sx, h_sy, h_de, h_hs, h_vs, h_ls, h_fs, h_ft} !== 29'd0) begin n_bad++;
            $display("FAIL reset_hd: got sx=%0d sy=%0d flags=%b, expected all 0", h_sx, h_sy, {h_de, h_hs, h_vs, h_ls, h_fs, h_ft}); end
    endtask

    task automatic test_first_edge();
        start();
        n_cmp++; if ({s_sx, s_sy} !== 7'd0) begin n_bad++; $display("FAIL first_pos: got sx=%0d sy=%0d, expected 0 0", s_sx, s_sy); end
        n_cmp++; if ({s_de, s_hs, s_vs} !== 3'b100) begin n_bad++; $display("FAIL first_de_sync: got %b, expected 100", {s_de, s_hs, s_vs}); end
        n_cmp++; if ({s_ls, s_fs, s_ft} !== 3'b111) begin n_bad++; $display("FAIL first_strobes: got %b, expected 111", {s_ls, s_fs, s_ft}); end
        n_cmp++; if ({h_sx, h_sy} !== 23'd0 || {h_de, h_hs, h_vs, h_ls, h_fs, h_ft} !== 6'b100111) begin n_bad++;
            $display("FAIL first_hd: got sx=%0d sy=%0d flags=%b, expected 0 0 100111", h_sx, h_sy, {h_de, h_hs, h_vs, h_ls, h_fs, h_ft}); end
    endtask

    task automatic test_line_scan();
        int de_bad = 0;
        int de_1919 = 0;
        int de_1920 = 1;
        int hs_cnt = 0;
        int hs_first = -1;
        int hs_last = -1;
        start();
        for (int i = 0; i < 2200; i++) begin
            if (i > 0) tick();
            if (h_de != (int'(h_sx) < 1920)) de_bad++;
            if (int'(h_sx) == 1919) de_1919 = int'(h_de);
            if (int'(h_sx) == 1920) de_1920 = int'(h_de);
            if (h_hs) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(h_sx);
                hs_last = int'(h_sx);
            end
        end
        n_cmp++; if (de_bad !== 0) begin n_bad++; $display("FAIL line_de_window: got %0d bad samples, expected 0", de_bad); end
        n_cmp++; if ({de_1919[0], de_1920[0]} !== 2'b10) begin n_bad++; $display("FAIL line_de_edge: got de@1919=%0d de@1920=%0d, expected 1 0", de_1919, de_1920); end
        n_cmp++; if (hs_cnt !== 44) begin n_bad++; $display("FAIL line_hsync_width: got %0d, expected 44", hs_cnt); end
        n_cmp++; if (hs_first !== 2008 || hs_last !== 2051) begin n_bad++; $display("FAIL line_hsync_pos: got %0d..%0d, expected 2008..2051", hs_first, hs_last); end
        tick();
        n_cmp++; if (int'(h_sx) !== 0 || int'(h_sy) !== 1) begin n_bad++; $display("FAIL line_wrap: got sx=%0d sy=%0d, expected 0 1", h_sx, h_sy); end
        n_cmp++; if ({h_ls, h_fs, h_de} !== 3'b101) begin n_bad++; $display("FAIL line_wrap_strobes: got ls/fs/de=%b, expected 101", {h_ls, h_fs, h_de}); end
    endtask

    task automatic test_frame_scan();
        int fs_cnt = 0, fs_bad = 0, last_fs = -1;
        int ft_cnt = 0, ft_bad = 0;
        int de_f0 = 0, hs_f0 = 0, vs_f0 = 0, vs_min = 99, vs_max = -1;
        int de_bad = 0, pos_bad = 0, ls_cnt = 0;
        start();
        for (int i = 0; i < 1080; i++) begin
            if (i > 0) tick();
            if (s_fs) begin
                fs_cnt++;
                if (last_fs >= 0 && i - last_fs != 120) fs_bad++;
                last_fs = i;
            end
            if (s_ft) begin
                ft_cnt++;
                if (!(i == 0 || i == 480 || i == 960) || !s_fs) ft_bad++;
            end
            if (i < 120 && s_de) de_f0++;
            if (i < 120 && s_hs) hs_f0++;
            if (i < 120 && s_vs) begin
                vs_f0++;
                if (int'(s_sy) < vs_min) vs_min = int'(s_sy);
                if (int'(s_sy) > vs_max) vs_max = int'(s_sy);
            end
            if (s_de && (int'(s_sx) >= 8 || int'(s_sy) >= 4)) de_bad++;
            if (int'(s_sx) != i % 15 || int'(s_sy) != (i / 15) % 8) pos_bad++;
            if (s_ls) ls_cnt++;
        end
        n_cmp++; if (fs_cnt !== 9) begin n_bad++; $display("FAIL frame_start_count: got %0d, expected 9", fs_cnt); end
        n_cmp++; if (fs_bad !== 0) begin n_bad++; $display("FAIL frame_period: got %0d bad intervals, expected 0", fs_bad); end
        n_cmp++; if (ft_cnt !== 3) begin n_bad++; $display("FAIL frame_tick_count: got %0d, expected 3", ft_cnt); end
        n_cmp++; if (ft_bad !== 0) begin n_bad++; $display("FAIL frame_tick_pos: got %0d misplaced, expected 0", ft_bad); end
        n_cmp++; if (de_f0 !== 32) begin n_bad++; $display("FAIL frame_de_count: got %0d, expected 32", de_f0); end
        n_cmp++; if (hs_f0 !== 24) begin n_bad++; $display("FAIL frame_hsync_count: got %0d, expected 24", hs_f0); end
        n_cmp++; if (vs_f0 !== 30) begin n_bad++; $display("FAIL frame_vsync_count: got %0d, expected 30", vs_f0); end
        n_cmp++; if (vs_min !== 5 || vs_max !== 6) begin n_bad++; $display("FAIL frame_vsync_lines: got %0d..%0d, expected 5..6", vs_min, vs_max); end
        n_cmp++; if (de_bad !== 0) begin n_bad++; $display("FAIL frame_de_blank: got %0d, expected 0", de_bad); end
        n_cmp++; if (pos_bad !== 0) begin n_bad++; $display("FAIL frame_position: got %0d bad, expected 0", pos_bad); end
        n_cmp++; if (ls_cnt !== 72) begin n_bad++; $display("FAIL frame_line_starts: got %0d, expected 72", ls_cnt); end
    endtask

    task automatic test_en_toggle();
        int p = 0;
        int bad = 0;
        int fs_j1 = -1, fs_j2 = -1;
        int ehc, evc;
        logic ede, ehs, evs, els, efs, eft;
        start();
        for (int j = 1; j <= 480; j++) begin
            en = (j % 2 == 0);
            tick();
            if (en) p++;
            ehc = p % 15;
            evc = (p / 15) % 8;
            ede = (ehc < 8) && (evc < 4);
            ehs = (ehc >= 10) && (ehc < 13);
            evs = (evc >= 5) && (evc < 7);
            els = (ehc == 0);
            efs = (p % 120 == 0);
            eft = efs && ((p / 120) % 4 == 0);
            if (int'(s_sx) != ehc || int'(s_sy) != evc ||
                {s_de, s_hs, s_vs, s_ls, s_fs, s_ft} !== {ede, ehs, evs, els, efs, eft}) bad++;
            if (en && s_fs) begin
                if (fs_j1 < 0) fs_j1 = j;
                else if (fs_j2 < 0) fs_j2 = j;
            end
        end
        en = 1'b1;
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL en_hold: got %0d bad samples, expected 0", bad); end
        n_cmp++; if (fs_j1 !== 240 || fs_j2 !== 480) begin n_bad++; $display("FAIL en_period: got frame starts at %0d,%0d, expected 240,480", fs_j1, fs_j2); end
    endtask

    task automatic test_reset_mid();
        start();
        repeat (155) tick();
        n_cmp++; if (int'(s_sx) !== 5 || int'(s_sy) !== 2 || s_de !== 1'b1) begin n_bad++;
            $display("FAIL mid_pos: got sx=%0d sy=%0d de=%0d, expected 5 2 1", s_sx, s_sy, s_de); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({s_sx, s_sy, s_de, s_hs, s_vs, s_ls, s_fs, s_ft} !== 13'd0) begin n_bad++;
            $display("FAIL mid_async_reset: got sx=%0d sy=%0d flags=%b, expected all 0", s_sx, s_sy, {s_de, s_hs, s_vs, s_ls, s_fs, s_ft}); end
        n_cmp++; if ({h_sx, h_sy, h_de} !== 24'd0) begin n_bad++; $display("FAIL mid_async_reset_hd: got sx=%0d sy=%0d de=%0d, expected 0 0 0", h_sx, h_sy, h_de); end
        repeat (2) tick();
        rst_n = 1'b1;
        en    = 1'b1;
        tick();
        n_cmp++; if ({s_sx, s_sy} !== 7'd0 || {s_de, s_ls, s_fs, s_ft} !== 4'b1111) begin n_bad++;
            $display("FAIL mid_restart: got sx=%0d sy=%0d de/ls/fs/ft=%b, expected 0 0 1111", s_sx, s_sy, {s_de, s_ls, s_fs, s_ft}); end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        test_reset();
        test_first_edge();
        test_line_scan();
        test_frame_scan();
        test_en_toggle();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
